// File: rtl/prga_pkg.sv
// Shared types and constants for the ARC4 pseudo-random generation stage.
//   byte_t       : 8-bit data/address type used throughout ARC4
//   LEN_ADDR     : address of the length prefix byte in CT/PT memories
//   prga_state_t : PRGA controller states
package prga_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t LEN_ADDR = 8'd0;

  typedef enum logic [3:0] {
    IDLE,
    WT_LEN,
    LAT_LEN,
    NEXT,
    WT_SI,
    LAT_SI,
    WT_SJ,
    LAT_SJ,
    WR_SJ,
    WR_SI,
    WT_PAD,
    LAT_PAD
  } prga_state_t;

endpackage

// File: rtl/prga_if.sv
// Memory-side bus of the PRGA stage: S RAM (read/write), CT RAM (read),
// PT RAM (write). All three RAMs are 256x8 with synchronous read.
//   master : the PRGA controller (drives addresses, write data, enables)
//   slave  : the RAM side (returns read data)
interface prga_if;
  import prga_pkg::*;

  byte_t s_addr;
  byte_t s_rddata;
  byte_t s_wrdata;
  logic  s_wren;
  byte_t ct_addr;
  byte_t ct_rddata;
  byte_t pt_addr;
  byte_t pt_wrdata;
  logic  pt_wren;

  modport master (
    output s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren,
    input  s_rddata, ct_rddata
  );

  modport slave (
    input  s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren,
    output s_rddata, ct_rddata
  );

endinterface

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage. Continues the S permutation left by
// key scheduling, produces the keystream and XORs it with the ciphertext
// (length-prefixed) to write length-prefixed plaintext.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   en   : start request, accepted only while rdy=1
//   rdy  : 1 = idle
//   bus  : prga_if.master, S/CT/PT RAM addresses, data and write enables
//          (all outputs registered)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | rdy=1, waiting for en
// WT_LEN  | CT length byte read in flight
// LAT_LEN | capture length, write it to PT[0], clear i/j/k
// NEXT    | done check, else advance i/k and request S[i]
// WT_SI   | S[i] read in flight
// LAT_SI  | capture S[i], update j, request S[j]
// WT_SJ   | S[j] read in flight
// LAT_SJ  | capture S[j], issue write S[i] <= S[j]
// WR_SJ   | issue write S[j] <= S[i]
// WR_SI   | both swap writes done; request pad S[si+sj] and CT[k]
// WT_PAD  | pad and CT reads in flight
// LAT_PAD | write PT[k] = pad ^ CT[k]
module prga
  import prga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rdy,
  prga_if.master bus
);

  prga_state_t state_q;
  logic  rdy_q;
  byte_t i_q, j_q, k_q, len_q, si_q, sj_q;
  byte_t s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
  logic  s_wren_q, pt_wren_q;

  assign rdy           = rdy_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wrdata  = s_wrdata_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses unless a state re-asserts them.
      s_wren_q  <= 1'b0;
      pt_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            rdy_q     <= 1'b0;
            ct_addr_q <= LEN_ADDR;
            state_q   <= WT_LEN;
          end
        end
        WT_LEN: state_q <= LAT_LEN;
        LAT_LEN: begin
          len_q       <= bus.ct_rddata;
          pt_addr_q   <= LEN_ADDR;
          pt_wrdata_q <= bus.ct_rddata;
          pt_wren_q   <= 1'b1;
          i_q         <= '0;
          j_q         <= '0;
          k_q         <= '0;
          state_q     <= NEXT;
        end
        NEXT: begin
          // k counts bytes done; comparing before increment lets L=255 end
          // without k ever wrapping.
          if (k_q == len_q) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            i_q      <= i_q + 8'd1;
            k_q      <= k_q + 8'd1;
            s_addr_q <= i_q + 8'd1;
            state_q  <= WT_SI;
          end
        end
        WT_SI: state_q <= LAT_SI;
        LAT_SI: begin
          si_q     <= bus.s_rddata;
          j_q      <= j_q + bus.s_rddata;
          s_addr_q <= j_q + bus.s_rddata;
          state_q  <= WT_SJ;
        end
        WT_SJ: state_q <= LAT_SJ;
        LAT_SJ: begin
          sj_q       <= bus.s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= bus.s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= WR_SJ;
        end
        WR_SJ: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= WR_SI;
        end
        WR_SI: begin
          // The pad address goes out only now so the RAM samples it after
          // both swap writes have landed.
          s_addr_q  <= si_q + sj_q;
          ct_addr_q <= k_q;
          state_q   <= WT_PAD;
        end
        WT_PAD: state_q <= LAT_PAD;
        LAT_PAD: begin
          pt_addr_q   <= k_q;
          pt_wrdata_q <= bus.s_rddata ^ bus.ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= NEXT;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prga.sv
module tb_prga;
  import prga_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic rdy;

  prga_if bus ();

  prga dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync-read RAMs
  byte_t s_mem  [256];
  byte_t s_init [256];
  byte_t ct_mem [256];
  byte_t pt_mem [256];
  logic  load_s;

  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (load_s) begin
      s_mem <= s_init;
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hAA;
    end else begin
      if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
      if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end
  end

  // Bus monitors
  int s_wr_cnt;
  int pt_wr_cnt;
  int overlap_cnt;
  logic [15:0] s_log[$];

  initial begin
    s_wr_cnt    = 0;
    pt_wr_cnt   = 0;
    overlap_cnt = 0;
  end

  always @(posedge clk) begin
    if (bus.s_wren) begin
      s_wr_cnt <= s_wr_cnt + 1;
      s_log.push_back({bus.s_addr, bus.s_wrdata});
    end
    if (bus.pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
    if (bus.s_wren && bus.pt_wren) overlap_cnt <= overlap_cnt + 1;
  end

  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ARC4 PRGA on m_s, starting from i=j=0, using ct_mem
  byte_t m_s  [256];
  byte_t m_pt [256];

  task automatic model_run();
    byte_t mi, mj, msi, msj, t;
    int l;
    l = int'(ct_mem[0]);
    m_pt[0] = ct_mem[0];
    mi = 8'd0;
    mj = 8'd0;
    for (int k = 1; k <= l; k++) begin
      mi = mi + 8'd1;
      msi = m_s[mi];
      mj = mj + msi;
      msj = m_s[mj];
      m_s[mi] = msj;
      m_s[mj] = msi;
      t = msi + msj;
      m_pt[k] = m_s[t] ^ ct_mem[k];
    end
  endtask

  task automatic load_mems();
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = byte_t'(x);
  endtask

  task automatic set_ct1();
    ct_mem[0] = 8'd3;
    ct_mem[1] = 8'h41;
    ct_mem[2] = 8'h42;
    ct_mem[3] = 8'h43;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!rdy && cyc < 5000);
  endtask

  task automatic check_test1(input string tag);
    int bad;
    check({tag, "_pt0"}, pt_mem[0], 8'h03);
    check({tag, "_pt1"}, pt_mem[1], 8'h43);
    check({tag, "_pt2"}, pt_mem[2], 8'h47);
    check({tag, "_pt3"}, pt_mem[3], 8'h44);
    check({tag, "_s2"}, s_mem[2], 8'd3);
    check({tag, "_s3"}, s_mem[3], 8'd5);
    check({tag, "_s5"}, s_mem[5], 8'd2);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (x != 2 && x != 3 && x != 5 && s_mem[x] !== byte_t'(x)) bad++;
    check({tag, "_s_rest"}, bad, 0);
  endtask

  initial begin
    int cyc, s0, p0, bad, r;
    byte_t tmp;
    logic [255:0] seen;
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    en     = 1'b0;
    load_s = 1'b0;
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_s_wren", bus.s_wren, 1'b0);
    check("rst_pt_wren", bus.pt_wren, 1'b0);
    check("rst_s_addr", bus.s_addr, 8'd0);
    check("rst_s_wrdata", bus.s_wrdata, 8'd0);
    check("rst_ct_addr", bus.ct_addr, 8'd0);
    check("rst_pt_addr", bus.pt_addr, 8'd0);
    check("rst_pt_wrdata", bus.pt_wrdata, 8'd0);
    rst = 1'b0;

    // Test 1/2: identity S, CT={3,41,42,43}
    set_identity();
    set_ct1();
    load_mems();
    s_log.delete();
    start_pulse();
    check("t1_busy", rdy, 1'b0);
    wait_rdy(cyc);
    check("t1_cycles", cyc, 30);
    check_test1("t1");
    check("t2_nwrites", s_log.size(), 6);
    if (s_log.size() >= 2) begin
      check("t2_wr0", s_log[0], 16'h0101);
      check("t2_wr1", s_log[1], 16'h0101);
    end
    check("t2_s1", s_mem[1], 8'd1);

    // Test 3: L=0
    set_identity();
    ct_mem[0] = 8'd0;
    load_mems();
    s0 = s_wr_cnt;
    p0 = pt_wr_cnt;
    start_pulse();
    wait_rdy(cyc);
    check("t3_cycles", cyc, 3);
    check("t3_pt0", pt_mem[0], 8'd0);
    check("t3_pt1_untouched", pt_mem[1], 8'hAA);
    check("t3_pt_writes", pt_wr_cnt - p0, 1);
    check("t3_s_writes", s_wr_cnt - s0, 0);

    // Test 4: random permutation, L=255
    set_identity();
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      tmp = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = tmp;
    end
    ct_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) ct_mem[x] = byte_t'($urandom_range(255, 0));
    m_s = s_init;
    model_run();
    load_mems();
    start_pulse();
    wait_rdy(cyc);
    check("t4_cycles", cyc, 2298);
    check("t4_pt0", pt_mem[0], 8'd255);
    bad = 0;
    for (int x = 1; x < 256; x++) if (pt_mem[x] !== m_pt[x]) bad++;
    check("t4_pt_mismatches", bad, 0);
    check("t4_pt255", pt_mem[255], m_pt[255]);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    check("t4_s_mismatches", bad, 0);
    seen = '0;
    for (int x = 0; x < 256; x++) seen[s_mem[x]] = 1'b1;
    check("t4_s_perm", (&seen) ? 1 : 0, 1);

    // Test 5: reset in LAT_SJ of byte 2, then rerun test 1
    set_identity();
    set_ct1();
    load_mems();
    start_pulse();
    repeat (15) @(posedge clk);
    #1;
    check("t5_in_lat_sj", dut.state_q, LAT_SJ);
    check("t5_k", dut.k_q, 8'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rdy", rdy, 1'b1);
    check("t5_s_wren", bus.s_wren, 1'b0);
    check("t5_pt_wren", bus.pt_wren, 1'b0);
    check("t5_state", dut.state_q, IDLE);
    rst = 1'b0;
    set_identity();
    load_mems();
    start_pulse();
    wait_rdy(cyc);
    check("t5_cycles", cyc, 30);
    check_test1("t5");

    // Test 6: en held high across a run
    set_identity();
    set_ct1();
    m_s = s_init;
    model_run();
    model_run();
    load_mems();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("t6_busy", rdy, 1'b0);
    wait_rdy(cyc);
    check("t6_cycles1", cyc, 30);
    check("t6_pt1_first", pt_mem[1], 8'h43);
    @(posedge clk);
    #1;
    check("t6_restart_rdy", rdy, 1'b0);
    check("t6_restart_state", dut.state_q, WT_LEN);
    en = 1'b0;
    wait_rdy(cyc);
    check("t6_cycles2", cyc, 30);
    bad = 0;
    for (int x = 0; x < 4; x++) if (pt_mem[x] !== m_pt[x]) bad++;
    check("t6_pt_mismatches", bad, 0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    check("t6_s_mismatches", bad, 0);

    check("wren_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
